// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    LAP
  } sw_state_t;

  // Command resolved from simultaneous pulses: clear > stop > start > lap.
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_STOP,
    CMD_START,
    CMD_LAP
  } sw_cmd_t;

  function automatic sw_cmd_t cmd_winner(input logic clear, input logic stop,
                                         input logic start, input logic lap);
    if (clear)      return CMD_CLEAR;
    else if (stop)  return CMD_STOP;
    else if (start) return CMD_START;
    else if (lap)   return CMD_LAP;
    else            return CMD_NONE;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// Single BCD digit counter with increment enable and ripple carry.
// Any value at or above 9 (including A-F) wraps to 0 and carries.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output bcd_digit_t q,
  output logic       carry_out
);

  bcd_digit_t r_q;
  logic       w_at_max;

  assign w_at_max  = (r_q >= BCD_MAX);
  assign carry_out = inc & w_at_max;
  assign q         = r_q;

  // Digit register: reset/clear to zero, otherwise step on increment enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= w_at_max ? '0 : r_q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/lap stopwatch controller driving a cascade of BCD digits
// from an internal prescaler.
module bcd_stopwatch_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  input  logic                  cmd_clear,
  input  logic                  cmd_lap,
  output logic [4*N_DIGITS-1:0] count_bcd,
  output logic [4*N_DIGITS-1:0] disp_bcd,
  output logic                  tick,
  output logic                  running,
  output logic                  overflow
);

  localparam int unsigned          PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  sw_state_t               r_state;
  logic [PRESC_W-1:0]      r_presc;
  logic [4*N_DIGITS-1:0]   r_lap;
  logic                    r_ovf;

  sw_cmd_t                 w_cmd;
  logic                    w_active;
  logic                    w_tick;
  logic                    w_clr;
  logic [N_DIGITS:0]       w_inc;
  logic [4*N_DIGITS-1:0]   w_count;

  assign w_cmd    = cmd_winner(cmd_clear, cmd_stop, cmd_start, cmd_lap);
  assign w_active = (r_state == RUN) || (r_state == LAP);
  assign w_tick   = ena & w_active & (r_presc == PRESC_LAST);
  assign w_clr    = ena & (w_cmd == CMD_CLEAR);

  // Digit i increments when tick is high and every lower digit is at 9;
  // that condition is exactly the carry out of digit i-1.
  assign w_inc[0] = w_tick;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .clr       (w_clr),
      .inc       (w_inc[gi]),
      .q         (w_count[4*gi +: 4]),
      .carry_out (w_inc[gi+1])
    );
  end

  // Control FSM with prescaler, lap register and sticky overflow.
  // Later assignments in the command case override the tick-driven updates,
  // so clear beats an increment committed on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_lap   <= '0;
      r_ovf   <= 1'b0;
    end else if (ena) begin
      if (w_active) begin
        r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PRESC_W'(1);
      end
      if (w_inc[N_DIGITS]) begin
        r_ovf <= 1'b1;
      end
      unique case (w_cmd)
        CMD_CLEAR: begin
          r_state <= IDLE;
          r_presc <= '0;
          r_lap   <= '0;
          r_ovf   <= 1'b0;
        end
        CMD_STOP: begin
          if (w_active) r_state <= HOLD;
        end
        CMD_START: begin
          if (r_state == IDLE) begin
            r_state <= RUN;
            r_presc <= '0;
          end else if (r_state == HOLD) begin
            r_state <= RUN;
          end
        end
        CMD_LAP: begin
          if (r_state == RUN) begin
            r_state <= LAP;
            r_lap   <= w_count;
          end else if (r_state == LAP) begin
            r_state <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_bcd = w_count;
  assign disp_bcd  = (r_state == LAP) ? r_lap : w_count;
  assign tick      = w_tick;
  assign running   = w_active;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench for bcd_stopwatch_ctrl against an integer-count
// reference model: directed scenarios followed by random command traffic.
module tb_bcd_stopwatch_ctrl;

  localparam int unsigned ND   = 2;
  localparam int unsigned TD   = 4;
  localparam int          MAXV = 100;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_LAP  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ena = 1'b0;
  logic            cmd_start = 1'b0;
  logic            cmd_stop  = 1'b0;
  logic            cmd_clear = 1'b0;
  logic            cmd_lap   = 1'b0;
  logic [4*ND-1:0] count_bcd;
  logic [4*ND-1:0] disp_bcd;
  logic            tick;
  logic            running;
  logic            overflow;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_cnt  = 0;
  int m_lap  = 0;
  int m_ph   = 0;
  int m_mode = M_IDLE;
  bit m_ovf  = 1'b0;

  bcd_stopwatch_ctrl #(
    .N_DIGITS (ND),
    .TICK_DIV (TD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cmd_clear (cmd_clear),
    .cmd_lap   (cmd_lap),
    .count_bcd (count_bcd),
    .disp_bcd  (disp_bcd),
    .tick      (tick),
    .running   (running),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int              x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(ND); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit m_active();
    return (m_mode == M_RUN) || (m_mode == M_LAP);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input bit cl,
                              input bit sp, input bit st, input bit lp);
    bit tk;
    int old;
    if (r) begin
      m_cnt = 0; m_lap = 0; m_ph = 0; m_mode = M_IDLE; m_ovf = 1'b0;
    end else if (e) begin
      tk  = m_active() && (m_ph == TD - 1);
      old = m_cnt;
      if (m_active()) m_ph = (m_ph + 1) % TD;
      if (tk) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == MAXV) begin
          m_cnt = 0;
          m_ovf = 1'b1;
        end
      end
      if (cl) begin
        m_cnt = 0; m_lap = 0; m_ph = 0; m_ovf = 1'b0; m_mode = M_IDLE;
      end else if (sp) begin
        if (m_active()) m_mode = M_HOLD;
      end else if (st) begin
        if (m_mode == M_IDLE) begin
          m_mode = M_RUN;
          m_ph   = 0;
        end else if (m_mode == M_HOLD) begin
          m_mode = M_RUN;
        end
      end else if (lp) begin
        if (m_mode == M_RUN) begin
          m_mode = M_LAP;
          m_lap  = old;
        end else if (m_mode == M_LAP) begin
          m_mode = M_RUN;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("count_bcd", 32'(count_bcd), 32'(to_bcd(m_cnt)));
    check("disp_bcd",  32'(disp_bcd),  32'(to_bcd(m_mode == M_LAP ? m_lap : m_cnt)));
    check("running",   32'(running),   32'(m_active()));
    check("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  // one clock cycle: drive, check tick, clock edge, update model, check outputs
  task automatic step(input bit r, input bit e, input bit cl,
                      input bit sp, input bit st, input bit lp);
    rst = r; ena = e; cmd_clear = cl; cmd_stop = sp; cmd_start = st; cmd_lap = lp;
    #1;
    if (!r) check("tick", 32'(tick), 32'(e && m_active() && (m_ph == TD - 1)));
    @(posedge clk);
    model_update(r, e, cl, sp, st, lp);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cmd(input bit cl, input bit sp, input bit st, input bit lp);
    step(1'b0, 1'b1, cl, sp, st, lp);
  endtask

  initial begin
    // reset for two cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rst_count", 32'(count_bcd), 32'h0);
    check("rst_run",   32'(running),   32'h0);

    // start and count 40 cycles
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    check("start_run", 32'(running), 32'h1);
    idle(40);
    check("after40", 32'(count_bcd), 32'h10);

    // run to 98, pause, hold ena low, resume with preserved phase
    idle(88 * 4);
    check("at98", 32'(count_bcd), 32'h98);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    check("at99", 32'(count_bcd), 32'h99);
    idle(4);
    check("wrap", 32'(count_bcd), 32'h00);
    check("ovf_set", 32'(overflow), 32'h1);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check("clr_ovf", 32'(overflow), 32'h0);
    check("clr_run", 32'(running), 32'h0);

    // lap freeze and release
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    idle(23 * 4);
    check("at23", 32'(count_bcd), 32'h23);
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    idle(15);
    check("lap_disp", 32'(disp_bcd), 32'h23);
    check("lap_cnt",  32'(count_bcd), 32'h27);
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("unlap", 32'(disp_bcd), 32'h27);

    // simultaneous start+stop+clear during RUN
    idle(5);
    cmd(1'b1, 1'b1, 1'b1, 1'b0);
    check("sim_clr_cnt", 32'(count_bcd), 32'h0);
    check("sim_clr_run", 32'(running), 32'h0);
    // stop+lap together: HOLD, lap register untouched
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    idle(9);
    cmd(1'b0, 1'b1, 1'b0, 1'b1);
    check("stoplap_run", 32'(running), 32'h0);

    // stop on the tick edge at 09
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    idle(39);
    check("at09", 32'(count_bcd), 32'h09);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    check("stop_tick", 32'(count_bcd), 32'h10);

    // reset mid-count in LAP at 57
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    idle(57 * 4);
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap57", 32'(disp_bcd), 32'h57);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_disp", 32'(disp_bcd), 32'h0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_idle", 32'(running), 32'h0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 11) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
- Run/pause/lap controller that sequences a chain of N_DIGITS BCD digit counters from single-cycle command pulses.
- A prescaler inside the block generates count ticks. Carries ripple digit to digit.
- A lap register freezes the displayed value while counting continues.
- Sits between the top-level I/O wrapper and the 7-segment/display driver, replacing free-running enable of the units counter.

Parameters:
- N_DIGITS, 4, number of cascaded BCD digits (1..8).
- TICK_DIV, 10, clk cycles per count increment (>=2).
- PRESC_W, $clog2(TICK_DIV), prescaler width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  global enable; 0 freezes all state (commands ignored).
- cmd_start  in  1  pulse: start or resume counting.
- cmd_stop  in  1  pulse: pause counting.
- cmd_clear  in  1  pulse: zero count, lap value and overflow; go IDLE.
- cmd_lap  in  1  pulse: freeze display (RUN) or release it (LAP).
- count_bcd  out  4*N_DIGITS  live count; digit 0 in bits [3:0].
- disp_bcd  out  4*N_DIGITS  count_bcd, or the frozen lap value in LAP.
- tick  out  1  strobe, high in the cycle an increment is committed.
- running  out  1  state is RUN or LAP.
- overflow  out  1  sticky: count wrapped past all 9s.

Behaviour:
- Reset (rst=1 at edge) sets: state IDLE; prescaler 0; count_bcd 0; lap register 0; disp_bcd 0; tick 0; running 0; overflow 0. Reset overrides ena and all commands, including mid-count.
- Reset or cmd_clear while IDLE or HOLD leaves the block in IDLE with running 0.
- FSM states: IDLE, RUN, HOLD, LAP. All transitions require ena=1.
  - IDLE: cmd_start -> RUN, prescaler cleared.
  - RUN: cmd_stop -> HOLD; cmd_lap -> LAP, lap register loaded with the current count_bcd.
  - HOLD: cmd_start -> RUN, prescaler preserved (resume mid-period).
  - LAP: cmd_lap -> RUN; cmd_stop -> HOLD (display unfreezes).
  - Any state: cmd_clear -> IDLE.
- Simultaneous commands are resolved by priority: clear > stop > start > lap. Only the winner acts; the others are dropped, not queued.
- Commands act at the edge where they are sampled. The new state is visible on running in the next cycle.
- Prescaler advances only when ena=1 and the state is RUN or LAP. It wraps at TICK_DIV-1 to 0.
- tick = ena & (RUN|LAP) & (prescaler==TICK_DIV-1), combinational from registers.
- At the edge where tick=1:
  - digit 0 increments;
  - a digit at 9 wraps to 0 and carries into the next digit in the same edge;
  - count_bcd shows the new value the following cycle.
- All digits 9 plus a tick: count becomes 0 and overflow is set. overflow stays set until cmd_clear or rst.
- An increment and cmd_stop on the same edge: the increment is committed, then the state becomes HOLD.
- An increment and cmd_lap on the same edge: the lap register captures the pre-increment value.
- An increment and cmd_clear on the same edge: clear wins; count becomes 0.
- Digits never hold values A-F. An illegal value, if forced, is treated as 9 (wraps to 0 with carry).
- disp_bcd is registered-equivalent: the lap register in LAP, otherwise count_bcd. No extra latency beyond count_bcd.
- ena=0: prescaler, count, FSM and lap register hold. tick is 0. Outputs hold their values.

Decomposition:
- Shared package bcd_pkg holds:
  - typedef bcd_digit_t (4-bit);
  - constant BCD_MAX = 4'd9;
  - state enum sw_state_t {IDLE, RUN, HOLD, LAP};
  - command-priority encoding.
- Sub-module bcd_digit: ports clk, rst, clr, inc, cin-style increment enable, q[3:0], carry_out. It is instantiated N_DIGITS times in a generate loop. Digit i increments on tick & (all lower digits == 9).
- The prescaler and FSM stay in the top module.

Test Plan (N_DIGITS=2, TICK_DIV=4 unless noted):
- rst high 2 cycles, then cmd_start pulse -> running=1 next cycle; tick every 4th cycle; count_bcd 0x00,0x01,... After 40 cycles count_bcd=0x10.
- Run to 0x98, stop (HOLD), hold ena=0 for 10 cycles, cmd_start -> resumes without losing prescaler phase; 0x99 then 0x00 with overflow=1; cmd_clear -> count 0x00, overflow=0, running=0.
- In RUN at 0x23, cmd_lap -> disp_bcd stays 0x23 while count_bcd reaches 0x27; cmd_lap again -> disp_bcd=count_bcd next cycle.
- cmd_start, cmd_stop and cmd_clear in the same cycle during RUN -> IDLE, count 0x00. cmd_stop and cmd_lap together -> HOLD, lap register unchanged.
- cmd_stop on a tick edge at 0x09 -> count_bcd=0x10, state HOLD, no further ticks.
- rst asserted mid-count at 0x57 in LAP -> all outputs 0 next cycle; a following cmd_lap is ignored (IDLE).
